// File: rtl/idu_scoreboard_ysyx_23060136_pkg.sv
// ---------------------------------------------------------------------------
// idu_scoreboard_ysyx_23060136_pkg
// Shared definitions for the ID-stage scoreboard:
//   - default widths of the per-register and total in-flight counters
//   - register file sizes tracked by the scoreboard
//   - issue-control FSM state encoding
//   - helper deciding whether an instruction creates a tracked writer
// ---------------------------------------------------------------------------
package idu_scoreboard_ysyx_23060136_pkg;

  localparam int SB_CNT_W   = 2;
  localparam int SB_TOT_W   = 4;
  localparam int SB_NUM_GPR = 32;
  localparam int SB_NUM_CSR = 8;

  typedef enum logic [1:0] {
    SB_RUN   = 2'd0,
    SB_DRAIN = 2'd1,
    SB_HALT  = 2'd2
  } sb_state_e;

  // x0 is hard-wired to zero, so a write to it never creates a pending writer.
  function automatic logic sb_is_tracked(input logic       write_gpr,
                                         input logic [4:0] rd,
                                         input logic       write_csr);
    return (write_gpr && (rd != 5'd0)) || write_csr;
  endfunction

endpackage

// File: rtl/idu_scoreboard_ysyx_23060136_cnt.sv
// ---------------------------------------------------------------------------
// IDU_SB_CNT_ysyx_23060136
// One saturating up/down counter of pending writers.
// Ports:
//   clk, rst   clock, asynchronous active-high reset (counter -> 0)
//   inc        one more writer issued
//   dec        one writer retired
//   cnt        current count
//   underflow  retirement seen while nothing is pending (protocol error)
// inc and dec together cancel out and leave the count unchanged.
// ---------------------------------------------------------------------------
module IDU_SB_CNT_ysyx_23060136
  import idu_scoreboard_ysyx_23060136_pkg::*;
#(
  parameter int W = SB_CNT_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         dec,
  output logic [W-1:0] cnt,
  output logic         underflow
);

  localparam logic [W-1:0] CNT_MAX = '1;

  assign underflow = dec & ~inc & (cnt == '0);

  // Increment sticks at the maximum and decrement sticks at zero; the issue
  // logic stalls before the top is reached, so the upper clamp is a guard.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (inc & ~dec) begin
      if (cnt != CNT_MAX) cnt <= cnt + W'(1);
    end else if (dec & ~inc) begin
      if (cnt != '0) cnt <= cnt - W'(1);
    end
  end

endmodule

// File: rtl/idu_scoreboard_ysyx_23060136.sv
// ---------------------------------------------------------------------------
// idu_scoreboard_ysyx_23060136
// ID-stage scoreboard: counts in-flight writers per GPR and per CSR, blocks
// issue on RAW hazards and counter saturation, serialises "serial"
// instructions behind an empty pipeline and freezes issue after a halt.
// Ports:
//   clk, rst                         clock, async active-high reset
//   IDU_i_valid / IDU_i_flush        decoded instruction present / killed
//   IDU_i_rs1/rs2, IDU_i_use_rs1/2   GPR sources
//   IDU_i_rd, IDU_i_write_gpr        GPR destination
//   IDU_i_csr_rs/read_csr            CSR source
//   IDU_i_csr_rd/write_csr           CSR destination
//   IDU_i_serial, IDU_i_halt         serialising / halting instruction
//   EXU_i_ready                      downstream accepts
//   WB_i_*                           retirement of a writer
//   IDU_o_issue                      instruction handed to EXU this cycle
//   IDU_o_ready                      ID may take a new instruction
//   SB_o_inflight                    tracked writers in flight
//   SB_o_halted                      halt reached
//   SB_o_err                         sticky retirement-without-writer error
// ---------------------------------------------------------------------------
module idu_scoreboard_ysyx_23060136
  import idu_scoreboard_ysyx_23060136_pkg::*;
#(
  parameter int CNT_W     = SB_CNT_W,
  parameter int TOT_W     = SB_TOT_W,
  parameter bit WB_BYPASS = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             IDU_i_valid,
  input  logic             IDU_i_flush,
  input  logic [4:0]       IDU_i_rs1,
  input  logic [4:0]       IDU_i_rs2,
  input  logic             IDU_i_use_rs1,
  input  logic             IDU_i_use_rs2,
  input  logic [4:0]       IDU_i_rd,
  input  logic             IDU_i_write_gpr,
  input  logic [2:0]       IDU_i_csr_rs,
  input  logic             IDU_i_read_csr,
  input  logic [2:0]       IDU_i_csr_rd,
  input  logic             IDU_i_write_csr,
  input  logic             IDU_i_serial,
  input  logic             IDU_i_halt,
  input  logic             EXU_i_ready,
  input  logic             WB_i_valid,
  input  logic [4:0]       WB_i_rd,
  input  logic             WB_i_RegWr,
  input  logic [2:0]       WB_i_csr_rd,
  input  logic             WB_i_CSRWr,
  output logic             IDU_o_issue,
  output logic             IDU_o_ready,
  output logic [TOT_W-1:0] SB_o_inflight,
  output logic             SB_o_halted,
  output logic             SB_o_err
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [TOT_W-1:0] TOT_MAX = '1;

  sb_state_e state;

  logic [CNT_W-1:0]      cnt_gpr [SB_NUM_GPR];
  logic [CNT_W-1:0]      cnt_csr [SB_NUM_CSR];
  logic [TOT_W-1:0]      total;
  logic [SB_NUM_GPR-1:0] gpr_inc, gpr_dec, gpr_uf;
  logic [SB_NUM_CSR-1:0] csr_inc, csr_dec, csr_uf;
  logic                  tot_inc, tot_dec, tot_uf;

  logic gpr_tracked, tracked;
  logic wb_gpr, wb_csr;
  logic [CNT_W-1:0] cnt_rs1, cnt_rs2, cnt_csrs;
  logic haz_rs1, haz_rs2, haz_csr, hazard, saturated;
  logic drain_done, permit, issue;

  assign gpr_tracked = IDU_i_write_gpr & (IDU_i_rd != 5'd0);
  assign tracked     = sb_is_tracked(IDU_i_write_gpr, IDU_i_rd, IDU_i_write_csr);
  assign wb_gpr      = WB_i_valid & WB_i_RegWr & (WB_i_rd != 5'd0);
  assign wb_csr      = WB_i_valid & WB_i_CSRWr;

  assign cnt_rs1  = cnt_gpr[IDU_i_rs1];
  assign cnt_rs2  = cnt_gpr[IDU_i_rs2];
  assign cnt_csrs = cnt_csr[IDU_i_csr_rs];

  // A source is only released early when the retiring writer is the last one
  // pending on it; an older-but-still-pending writer keeps the hazard.
  assign haz_rs1 = IDU_i_use_rs1 & (IDU_i_rs1 != 5'd0) & (cnt_rs1 != '0)
                 & ~(WB_BYPASS & wb_gpr & (WB_i_rd == IDU_i_rs1) & (cnt_rs1 == CNT_W'(1)));
  assign haz_rs2 = IDU_i_use_rs2 & (IDU_i_rs2 != 5'd0) & (cnt_rs2 != '0)
                 & ~(WB_BYPASS & wb_gpr & (WB_i_rd == IDU_i_rs2) & (cnt_rs2 == CNT_W'(1)));
  assign haz_csr = IDU_i_read_csr & (cnt_csrs != '0)
                 & ~(WB_BYPASS & wb_csr & (WB_i_csr_rd == IDU_i_csr_rs) & (cnt_csrs == CNT_W'(1)));
  assign hazard  = haz_rs1 | haz_rs2 | haz_csr;

  // Saturation looks at the registered counts only; a same-cycle retirement
  // frees the slot for the next cycle.
  assign saturated = (gpr_tracked & (cnt_gpr[IDU_i_rd] == CNT_MAX))
                   | (IDU_i_write_csr & (cnt_csr[IDU_i_csr_rd] == CNT_MAX))
                   | (tracked & (total == TOT_MAX));

  // The pipeline counts as empty in DRAIN if the last writer retires now.
  assign drain_done = (total == '0) | ((total == TOT_W'(1)) & (wb_gpr | wb_csr));

  always_comb begin
    permit = 1'b0;
    case (state)
      SB_RUN:   permit = ~IDU_i_serial | (total == '0);
      SB_DRAIN: permit = drain_done;
      default:  permit = 1'b0;
    endcase
  end

  assign issue       = IDU_i_valid & ~IDU_i_flush & EXU_i_ready & ~hazard & ~saturated & permit;
  assign IDU_o_issue = issue;
  assign IDU_o_ready = (state != SB_HALT) & (issue | ~IDU_i_valid | IDU_i_flush);

  // One counter per architectural register; x0 gets one too but never moves.
  for (genvar g = 0; g < SB_NUM_GPR; g++) begin : g_gpr_cnt
    assign gpr_inc[g] = issue & gpr_tracked & (IDU_i_rd == 5'(g));
    assign gpr_dec[g] = wb_gpr & (WB_i_rd == 5'(g));
    IDU_SB_CNT_ysyx_23060136 #(.W(CNT_W)) u_cnt (
      .clk(clk), .rst(rst), .inc(gpr_inc[g]), .dec(gpr_dec[g]),
      .cnt(cnt_gpr[g]), .underflow(gpr_uf[g])
    );
  end

  for (genvar c = 0; c < SB_NUM_CSR; c++) begin : g_csr_cnt
    assign csr_inc[c] = issue & IDU_i_write_csr & (IDU_i_csr_rd == 3'(c));
    assign csr_dec[c] = wb_csr & (WB_i_csr_rd == 3'(c));
    IDU_SB_CNT_ysyx_23060136 #(.W(CNT_W)) u_cnt (
      .clk(clk), .rst(rst), .inc(csr_inc[c]), .dec(csr_dec[c]),
      .cnt(cnt_csr[c]), .underflow(csr_uf[c])
    );
  end

  // A retirement writing both a GPR and a CSR is still a single writer.
  assign tot_inc = issue & tracked;
  assign tot_dec = wb_gpr | wb_csr;

  IDU_SB_CNT_ysyx_23060136 #(.W(TOT_W)) u_total (
    .clk(clk), .rst(rst), .inc(tot_inc), .dec(tot_dec),
    .cnt(total), .underflow(tot_uf)
  );

  assign SB_o_inflight = total;

  // Issue-control FSM: a halting issue wins from any state and HALT is
  // absorbing; a serial instruction waits in DRAIN until the pipeline empties
  // or the instruction is flushed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= SB_RUN;
      SB_o_halted <= 1'b0;
    end else if (issue & IDU_i_halt) begin
      state       <= SB_HALT;
      SB_o_halted <= 1'b1;
    end else begin
      case (state)
        SB_RUN: begin
          if (IDU_i_valid & IDU_i_serial & ~IDU_i_flush & (total != '0))
            state <= SB_DRAIN;
        end
        SB_DRAIN: begin
          if (issue | IDU_i_flush)
            state <= SB_RUN;
        end
        default: state <= state;
      endcase
    end
  end

  // Any retirement that finds nothing pending latches the error until reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      SB_o_err <= 1'b0;
    else if ((|gpr_uf) | (|csr_uf) | tot_uf)
      SB_o_err <= 1'b1;
  end

endmodule

// File: tb/tb_idu_scoreboard_ysyx_23060136.sv
// ---------------------------------------------------------------------------
// tb_idu_scoreboard_ysyx_23060136
// Directed bench for the ID-stage scoreboard: a cycle-by-cycle vector table
// followed by hand-written reset and halt sequences.
// ---------------------------------------------------------------------------
module tb_idu_scoreboard_ysyx_23060136;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       IDU_i_valid, IDU_i_flush;
  logic [4:0] IDU_i_rs1, IDU_i_rs2, IDU_i_rd;
  logic       IDU_i_use_rs1, IDU_i_use_rs2, IDU_i_write_gpr;
  logic [2:0] IDU_i_csr_rs, IDU_i_csr_rd;
  logic       IDU_i_read_csr, IDU_i_write_csr;
  logic       IDU_i_serial, IDU_i_halt, EXU_i_ready;
  logic       WB_i_valid, WB_i_RegWr, WB_i_CSRWr;
  logic [4:0] WB_i_rd;
  logic [2:0] WB_i_csr_rd;
  logic       IDU_o_issue, IDU_o_ready, SB_o_halted, SB_o_err;
  logic [3:0] SB_o_inflight;

  int nApplied = 0;
  int nMiss    = 0;

  idu_scoreboard_ysyx_23060136 dut (
    .clk(clk), .rst(rst),
    .IDU_i_valid(IDU_i_valid), .IDU_i_flush(IDU_i_flush),
    .IDU_i_rs1(IDU_i_rs1), .IDU_i_rs2(IDU_i_rs2),
    .IDU_i_use_rs1(IDU_i_use_rs1), .IDU_i_use_rs2(IDU_i_use_rs2),
    .IDU_i_rd(IDU_i_rd), .IDU_i_write_gpr(IDU_i_write_gpr),
    .IDU_i_csr_rs(IDU_i_csr_rs), .IDU_i_read_csr(IDU_i_read_csr),
    .IDU_i_csr_rd(IDU_i_csr_rd), .IDU_i_write_csr(IDU_i_write_csr),
    .IDU_i_serial(IDU_i_serial), .IDU_i_halt(IDU_i_halt),
    .EXU_i_ready(EXU_i_ready),
    .WB_i_valid(WB_i_valid), .WB_i_rd(WB_i_rd), .WB_i_RegWr(WB_i_RegWr),
    .WB_i_csr_rd(WB_i_csr_rd), .WB_i_CSRWr(WB_i_CSRWr),
    .IDU_o_issue(IDU_o_issue), .IDU_o_ready(IDU_o_ready),
    .SB_o_inflight(SB_o_inflight), .SB_o_halted(SB_o_halted), .SB_o_err(SB_o_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic       valid, flush;
    logic [4:0] rs1, rs2, rd;
    logic       use1, use2, wgpr;
    logic [2:0] csr_rs, csr_rd;
    logic       rcsr, wcsr, serial, halt, exu_ready;
    logic       wbv;
    logic [4:0] wb_rd;
    logic       wb_regwr;
    logic [2:0] wb_csr_rd;
    logic       wb_csrwr;
    logic       e_issue, e_ready;
    logic [3:0] e_infl;
    logic       e_err, e_halt;
  } vec_t;

  vec_t vecs[$];

  // Builds a GPR-only vector; CSR, rs2 and flush fields are patched afterwards.
  function automatic vec_t mk(input string name, input logic valid, input logic [4:0] rd,
                              input logic wgpr, input logic [4:0] rs1, input logic use1,
                              input logic serial, input logic wbv, input logic [4:0] wb_rd,
                              input logic e_issue, input logic e_ready,
                              input logic [3:0] e_infl, input logic e_err);
    vec_t v;
    v.name = name;      v.valid = valid;   v.flush = 1'b0;
    v.rs1 = rs1;        v.rs2 = 5'd0;      v.rd = rd;
    v.use1 = use1;      v.use2 = 1'b0;     v.wgpr = wgpr;
    v.csr_rs = 3'd0;    v.csr_rd = 3'd0;   v.rcsr = 1'b0;  v.wcsr = 1'b0;
    v.serial = serial;  v.halt = 1'b0;     v.exu_ready = 1'b1;
    v.wbv = wbv;        v.wb_rd = wb_rd;   v.wb_regwr = wbv;
    v.wb_csr_rd = 3'd0; v.wb_csrwr = 1'b0;
    v.e_issue = e_issue; v.e_ready = e_ready; v.e_infl = e_infl;
    v.e_err = e_err;    v.e_halt = 1'b0;
    return v;
  endfunction

  task automatic applyStimulus(input vec_t v);
    IDU_i_valid = v.valid;   IDU_i_flush = v.flush;
    IDU_i_rs1 = v.rs1;       IDU_i_rs2 = v.rs2;      IDU_i_rd = v.rd;
    IDU_i_use_rs1 = v.use1;  IDU_i_use_rs2 = v.use2; IDU_i_write_gpr = v.wgpr;
    IDU_i_csr_rs = v.csr_rs; IDU_i_csr_rd = v.csr_rd;
    IDU_i_read_csr = v.rcsr; IDU_i_write_csr = v.wcsr;
    IDU_i_serial = v.serial; IDU_i_halt = v.halt;    EXU_i_ready = v.exu_ready;
    WB_i_valid = v.wbv;      WB_i_rd = v.wb_rd;      WB_i_RegWr = v.wb_regwr;
    WB_i_csr_rd = v.wb_csr_rd; WB_i_CSRWr = v.wb_csrwr;
  endtask

  task automatic checkOutput(input string name, input logic e_issue, input logic e_ready,
                             input logic [3:0] e_infl, input logic e_err, input logic e_halt);
    nApplied++;
    if (IDU_o_issue !== e_issue || IDU_o_ready !== e_ready || SB_o_inflight !== e_infl ||
        SB_o_err !== e_err || SB_o_halted !== e_halt) begin
      nMiss++;
      $display("[TB] FAIL %s: got issue=%b ready=%b inflight=%0d err=%b halted=%b, want issue=%b ready=%b inflight=%0d err=%b halted=%b",
               name, IDU_o_issue, IDU_o_ready, SB_o_inflight, SB_o_err, SB_o_halted,
               e_issue, e_ready, e_infl, e_err, e_halt);
    end
  endtask

  initial begin
    vec_t v;

    // name               valid rd wgpr rs1 use1 ser wbv wbrd  iss rdy infl err
    vecs.push_back(mk("idle_reset",      0, 0, 0, 0, 0, 0, 0, 0,  0, 1, 0, 0));
    vecs.push_back(mk("addi_x5",         1, 5, 1, 0, 0, 0, 0, 0,  1, 1, 0, 0));
    vecs.push_back(mk("add_rs1_x5_haz",  1, 6, 1, 5, 1, 0, 0, 0,  0, 0, 1, 0));
    vecs.push_back(mk("add_wb_bypass",   1, 6, 1, 5, 1, 0, 1, 5,  1, 1, 1, 0));
    vecs.push_back(mk("x7_writer1",      1, 7, 1, 0, 0, 0, 0, 0,  1, 1, 1, 0));
    vecs.push_back(mk("x7_writer2",      1, 7, 1, 0, 0, 0, 0, 0,  1, 1, 2, 0));
    vecs.push_back(mk("x7_writer3",      1, 7, 1, 0, 0, 0, 0, 0,  1, 1, 3, 0));
    vecs.push_back(mk("x7_writer4_sat",  1, 7, 1, 0, 0, 0, 0, 0,  0, 0, 4, 0));
    vecs.push_back(mk("x7_sat_with_wb",  1, 7, 1, 0, 0, 0, 1, 7,  0, 0, 4, 0));
    vecs.push_back(mk("x7_writer4_go",   1, 7, 1, 0, 0, 0, 0, 0,  1, 1, 3, 0));
    vecs.push_back(mk("wb_x6",           0, 0, 0, 0, 0, 0, 1, 6,  0, 1, 4, 0));
    vecs.push_back(mk("wb_x7_a",         0, 0, 0, 0, 0, 0, 1, 7,  0, 1, 3, 0));
    vecs.push_back(mk("ecall_to_drain",  1, 0, 0, 0, 0, 1, 0, 0,  0, 0, 2, 0));
    vecs.push_back(mk("ecall_wait_wb",   1, 0, 0, 0, 0, 1, 1, 7,  0, 0, 2, 0));
    vecs.push_back(mk("ecall_last_wb",   1, 0, 0, 0, 0, 1, 1, 7,  1, 1, 1, 0));
    vecs.push_back(mk("x8_after_drain",  1, 8, 1, 0, 0, 0, 0, 0,  1, 1, 0, 0));
    vecs.push_back(mk("serial_drain2",   1, 0, 0, 0, 0, 1, 0, 0,  0, 0, 1, 0));
    v = mk("serial_flushed",             1, 0, 0, 0, 0, 1, 0, 0,  0, 1, 1, 0);
    v.flush = 1'b1;
    vecs.push_back(v);
    vecs.push_back(mk("run_after_flush", 1, 10, 1, 0, 0, 0, 0, 0, 1, 1, 1, 0));
    vecs.push_back(mk("x0_write",        1, 0, 1, 0, 0, 0, 0, 0,  1, 1, 2, 0));
    vecs.push_back(mk("rs1_x0_consumer", 1, 0, 1, 0, 1, 0, 0, 0,  1, 1, 2, 0));
    v = mk("csr_write_3",                1, 0, 0, 0, 0, 0, 0, 0,  1, 1, 2, 0);
    v.wcsr = 1'b1; v.csr_rd = 3'd3;
    vecs.push_back(v);
    v = mk("csr_read_haz",               1, 0, 0, 0, 0, 0, 0, 0,  0, 0, 3, 0);
    v.rcsr = 1'b1; v.csr_rs = 3'd3;
    vecs.push_back(v);
    v = mk("csr_read_bypass",            1, 0, 0, 0, 0, 0, 0, 0,  1, 1, 3, 0);
    v.rcsr = 1'b1; v.csr_rs = 3'd3; v.wbv = 1'b1; v.wb_regwr = 1'b0;
    v.wb_csrwr = 1'b1; v.wb_csr_rd = 3'd3;
    vecs.push_back(v);
    v = mk("rs2_x8_haz",                 1, 0, 0, 0, 0, 0, 0, 0,  0, 0, 2, 0);
    v.rs2 = 5'd8; v.use2 = 1'b1;
    vecs.push_back(v);
    v = mk("flush_kills_id",             1, 11, 1, 0, 0, 0, 0, 0, 0, 1, 2, 0);
    v.flush = 1'b1;
    vecs.push_back(v);
    v = mk("exu_not_ready",              1, 11, 1, 0, 0, 0, 0, 0, 0, 0, 2, 0);
    v.exu_ready = 1'b0;
    vecs.push_back(v);
    vecs.push_back(mk("wb_x9_unpaired",  0, 0, 0, 0, 0, 0, 1, 9,  0, 1, 2, 0));
    vecs.push_back(mk("err_sticky",      0, 0, 0, 0, 0, 0, 0, 0,  0, 1, 1, 1));

    applyStimulus(mk("init", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    repeat (2) @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i]);
      #1;
      checkOutput(vecs[i].name, vecs[i].e_issue, vecs[i].e_ready, vecs[i].e_infl,
                  vecs[i].e_err, vecs[i].e_halt);
      @(negedge clk);
    end

    // Reset in the middle of a cycle clears everything without a clock edge.
    applyStimulus(mk("idle", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    #2 rst = 1'b1;
    #1 checkOutput("reset_async", 1'b0, 1'b1, 4'd0, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    applyStimulus(mk("x8_consumer", 1, 0, 0, 8, 1, 0, 0, 0, 0, 0, 0, 0));
    #1 checkOutput("x8_free_after_reset", 1'b1, 1'b1, 4'd0, 1'b0, 1'b0);
    @(negedge clk);
    applyStimulus(mk("stale_wb", 0, 0, 0, 0, 0, 0, 1, 10, 0, 0, 0, 0));
    #1 checkOutput("stale_wb_cycle", 1'b0, 1'b1, 4'd0, 1'b0, 1'b0);
    @(negedge clk);
    applyStimulus(mk("idle", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    #1 checkOutput("stale_wb_err", 1'b0, 1'b1, 4'd0, 1'b1, 1'b0);
    @(negedge clk);

    // Halting instruction, then ten cycles of nothing getting through.
    v = mk("halt_issue", 1, 13, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    v.halt = 1'b1;
    applyStimulus(v);
    #1 checkOutput("halt_issue", 1'b1, 1'b1, 4'd0, 1'b1, 1'b0);
    @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      applyStimulus(mk("halted", logic'(i % 2 == 0), 14, 1, 0, 0, 0, logic'(i == 0), 13,
                       0, 0, 0, 0));
      #1 checkOutput($sformatf("halted_cycle%0d", i), 1'b0, 1'b0,
                     (i == 0) ? 4'd1 : 4'd0, 1'b1, 1'b1);
      @(negedge clk);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nApplied, nMiss);
    $finish;
  end

endmodule
